// File: rtl/vm_pkg.sv
// Shared types, default timing constants and leader search for the voting machine.
package vm_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, ACK, RESULT} state_t;

   localparam int DEF_DEBOUNCE_CYC = 100000000;
   localparam int DEF_ACK_CYC      = 100000000;

   // Upper bounds of the candidate count and tally width that find_leader accepts
   localparam int MAX_CAND  = 16;
   localparam int MAX_CNT_W = 32;

   typedef struct packed {
      logic [3:0] idx;
      logic       tie;
   } lead_t;

   // Index of the largest tally (lowest index on equal max) and a tie flag for a non-zero shared max
   function automatic lead_t find_leader(input logic [MAX_CAND-1:0][MAX_CNT_W-1:0] t, input int n);
      lead_t                r;
      logic [MAX_CNT_W-1:0] mx;
      int                   hits;
      r    = '0;
      mx   = '0;
      hits = 0;
      for (int i = 0; i < MAX_CAND; i++) begin
         if (i < n && t[i] > mx) begin
            mx    = t[i];
            r.idx = 4'(i);
         end
      end
      for (int i = 0; i < MAX_CAND; i++) begin
         if (i < n && t[i] == mx) hits++;
      end
      r.tie = (mx != '0) && (hits >= 2);
      return r;
   endfunction

endpackage

// File: rtl/vm_debounce.sv
// Per-button debouncer: one press pulse after DEBOUNCE_CYC consecutive high samples.
module vm_debounce #(
   parameter int DEBOUNCE_CYC = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int             CW  = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0]  LIM = CW'(DEBOUNCE_CYC);
   localparam logic [CW-1:0]  PRE = CW'(DEBOUNCE_CYC - 1);

   logic [CW-1:0] cnt;

   // The pulse is registered on the same edge that moves the counter onto LIM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= btn && (cnt == PRE);
         if (!btn)
            cnt <= '0;
         else if (cnt != LIM)
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/param_voting_machine.sv
// One-vote-per-arm voting machine with saturating tallies, timed acknowledge and result display.
module param_voting_machine
   import vm_pkg::*;
#(
   parameter  int NUM_CAND     = 4,
   parameter  int CNT_W        = 10,
   parameter  int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter  int ACK_CYC      = DEF_ACK_CYC,
   localparam int IDX_W        = $clog2(NUM_CAND)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic                arm,
   input  logic [NUM_CAND-1:0] btn,
   output logic [CNT_W-1:0]    result,
   output logic                vote_ack,
   output logic                armed,
   output logic [IDX_W-1:0]    winner,
   output logic                tie,
   output logic                sat
);

   localparam int            AW       = $clog2(ACK_CYC + 1);
   localparam logic [AW-1:0] ACK_LOAD = AW'(ACK_CYC - 1);

   state_t                               state;
   logic [NUM_CAND-1:0]                  press;
   logic [CNT_W-1:0]                     tally [NUM_CAND];
   logic [AW-1:0]                        ack_timer;
   logic [IDX_W-1:0]                     pick;
   logic                                 any_press;
   logic [MAX_CAND-1:0][MAX_CNT_W-1:0]   tally_ext;
   lead_t                                lead;

   for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_deb
      vm_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn[gi]),
         .press (press[gi])
      );
   end

   // Lowest-index pulse wins when several arrive together
   always_comb begin
      pick      = '0;
      any_press = 1'b0;
      for (int i = NUM_CAND - 1; i >= 0; i--) begin
         if (press[i]) begin
            pick      = IDX_W'(i);
            any_press = 1'b1;
         end
      end
   end

   always_comb begin
      tally_ext = '0;
      for (int i = 0; i < NUM_CAND; i++) tally_ext[i] = MAX_CNT_W'(tally[i]);
      lead = find_leader(tally_ext, NUM_CAND);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ack_timer <= '0;
         result    <= '0;
         vote_ack  <= 1'b0;
         armed     <= 1'b0;
         winner    <= '0;
         tie       <= 1'b0;
         sat       <= 1'b0;
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
      end else begin
         winner <= '0;
         tie    <= 1'b0;
         // Result mode overrides everything; an aborted ACK keeps its vote
         if (mode && state != RESULT) begin
            state    <= RESULT;
            result   <= '0;
            vote_ack <= 1'b0;
            armed    <= 1'b0;
            winner   <= IDX_W'(lead.idx);
            tie      <= lead.tie;
         end else begin
            case (state)
               IDLE: begin
                  result <= '0;
                  if (arm) begin
                     state <= ARMED;
                     armed <= 1'b1;
                  end
               end
               ARMED: begin
                  if (any_press) begin
                     if (tally[pick] == '1)
                        sat <= 1'b1;
                     else
                        tally[pick] <= tally[pick] + 1'b1;
                     ack_timer <= ACK_LOAD;
                     state     <= ACK;
                     armed     <= 1'b0;
                     vote_ack  <= 1'b1;
                     result    <= '1;
                  end
               end
               ACK: begin
                  if (ack_timer == '0) begin
                     state    <= IDLE;
                     vote_ack <= 1'b0;
                     result   <= '0;
                  end else begin
                     ack_timer <= ack_timer - 1'b1;
                  end
               end
               RESULT: begin
                  if (!mode) begin
                     state  <= IDLE;
                     result <= '0;
                  end else begin
                     winner <= IDX_W'(lead.idx);
                     tie    <= lead.tie;
                     if (any_press) result <= tally[pick];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_param_voting_machine.sv
// Randomised self-checking bench for param_voting_machine against a vote-level tally model.
module tb_param_voting_machine;

   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mode = 1'b0;
   logic          arm = 1'b0;
   logic [NC-1:0] btn = '0;
   logic [2:0]    result;
   logic          vote_ack;
   logic          armed;
   logic [1:0]    winner;
   logic          tie;
   logic          sat;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_tally [NC];
   bit exp_sat;

   param_voting_machine #(
      .NUM_CAND(NC), .CNT_W(3), .DEBOUNCE_CYC(4), .ACK_CYC(3)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .arm(arm), .btn(btn),
      .result(result), .vote_ack(vote_ack), .armed(armed),
      .winner(winner), .tie(tie), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int model_max();
      int m = 0;
      for (int i = 0; i < NC; i++) if (exp_tally[i] > m) m = exp_tally[i];
      return m;
   endfunction

   function automatic int model_winner();
      int m = model_max();
      for (int i = 0; i < NC; i++) if (exp_tally[i] == m) return i;
      return 0;
   endfunction

   function automatic int model_tie();
      int m = model_max();
      int k = 0;
      for (int i = 0; i < NC; i++) if (exp_tally[i] == m) k++;
      return (m > 0 && k >= 2) ? 1 : 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) exp_tally[i] = 0;
      exp_sat = 0;
      $display("[TB] reset");
   endtask

   task automatic vote(input logic [NC-1:0] mask);
      int c = 0;
      int acks = 0;
      for (int i = NC - 1; i >= 0; i--) if (mask[i]) c = i;
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      check("armed_after_arm", armed, 1);
      btn = mask;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (vote_ack) begin
            acks++;
            check("ack_result", result, 7);
         end
         if (k == 6) btn = '0;
      end
      if (exp_tally[c] == 7) exp_sat = 1;
      else exp_tally[c]++;
      check("ack_len", acks, 3);
      check("idle_result", result, 0);
      check("idle_armed", armed, 0);
      check("sat", sat, exp_sat);
      $display("[TB] vote mask=%b -> cand %0d model tally=%0d", mask, c, exp_tally[c]);
   endtask

   task automatic press_idle(input logic [NC-1:0] mask);
      int acks = 0;
      btn = mask;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (vote_ack) acks++;
         if (k == 6) btn = '0;
      end
      check("idle_press_ack", acks, 0);
      check("idle_press_armed", armed, 0);
      $display("[TB] unarmed press mask=%b", mask);
   endtask

   task automatic enter_result();
      mode = 1'b1;
      repeat (2) @(negedge clk);
      check("winner", winner, model_winner());
      check("tie", tie, model_tie());
      $display("[TB] result mode winner=%0d tie=%0d", winner, tie);
   endtask

   task automatic read_cand(input int c);
      btn = NC'(1) << c;
      repeat (6) @(negedge clk);
      btn = '0;
      @(negedge clk);
      check($sformatf("tally%0d", c), result, exp_tally[c]);
      check("winner_rd", winner, model_winner());
      check("tie_rd", tie, model_tie());
      $display("[TB] read cand %0d result=%0d", c, result);
   endtask

   task automatic exit_result();
      mode = 1'b0;
      @(negedge clk);
      check("exit_result", result, 0);
      check("exit_winner", winner, 0);
      check("exit_tie", tie, 0);
      $display("[TB] exit result mode");
   endtask

   task automatic read_all();
      enter_result();
      for (int c = 0; c < NC; c++) read_cand(c);
      exit_result();
   endtask

   initial begin
      int got_ack;
      for (int i = 0; i < NC; i++) exp_tally[i] = 0;
      exp_sat = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_ack", vote_ack, 0);
      check("rst_armed", armed, 0);
      check("rst_winner", winner, 0);
      check("rst_tie", tie, 0);
      check("rst_sat", sat, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single vote, unarmed press, re-press after the vote
      vote(4'b0100);
      press_idle(4'b0010);
      vote(4'b0010);
      press_idle(4'b0010);
      // Simultaneous press: lowest index wins
      vote(4'b1001);
      read_all();

      // Bouncing button while armed never registers
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      got_ack = 0;
      for (int r = 0; r < 8; r++) begin
         btn = 4'b1000;
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            if (vote_ack) got_ack++;
         end
         btn = '0;
         repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      check("bounce_ack", got_ack, 0);
      check("bounce_armed", armed, 1);
      $display("[TB] bounce sequence done");
      vote(4'b0001);

      // Saturation then reset
      do_reset();
      for (int i = 0; i < 8; i++) vote(4'b0010);
      check("sat_set", sat, 1);
      read_all();
      do_reset();
      check("sat_clr", sat, 0);
      read_all();

      // Tie and winner in result mode
      for (int i = 0; i < 2; i++) vote(4'b0001);
      for (int i = 0; i < 5; i++) vote(4'b0010);
      for (int i = 0; i < 5; i++) vote(4'b0100);
      vote(4'b1000);
      enter_result();
      read_cand(3);
      exit_result();
      vote(4'b0100);
      enter_result();
      read_cand(2);
      exit_result();

      // Asynchronous reset in the middle of an acknowledge
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      btn = 4'b0001;
      got_ack = 0;
      for (int k = 0; k < 10 && !got_ack; k++) begin
         @(negedge clk);
         if (vote_ack) got_ack = 1;
      end
      check("ack_seen", got_ack, 1);
      btn = '0;
      #2 rst = 1'b1;
      #1;
      check("async_ack", vote_ack, 0);
      check("async_result", result, 0);
      check("async_armed", armed, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NC; i++) exp_tally[i] = 0;
      exp_sat = 0;
      $display("[TB] async reset during ack");
      read_all();

      // Random traffic
      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 3))
            0, 1: vote(NC'($urandom_range(1, 15)));
            2: begin
               enter_result();
               read_cand($urandom_range(0, NC - 1));
               exit_result();
            end
            default: press_idle(NC'($urandom_range(1, 15)));
         endcase
      end
      read_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_voting_machine.md
Name: param_voting_machine

Overview:
Parametrised successor of the four-candidate voting machine. Adds the following:
- NUM_CAND debounced candidate channels.
- CNT_W-bit saturating tallies.
- An arm/ack handshake that permits exactly one vote per voter.
- A timed acknowledge display.
- A result mode that shows the per-candidate tally plus the winner index and a tie flag.

It sits at top level between the raw board buttons/switches and the LED display.

Parameters:
NUM_CAND, 4, number of candidates/buttons (2..16)
CNT_W, 10, width of each tally and of result
DEBOUNCE_CYC, 100000000, consecutive high cycles required to register a press
ACK_CYC, 100000000, cycles the vote-accepted display is held
IDX_W, $clog2(NUM_CAND), localparam, width of winner index

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
mode  input  1  0 = voting, 1 = result display
arm  input  1  officer enable; a level-high sample arms one vote
btn  input  NUM_CAND  raw candidate buttons, bit i = candidate i
result  output  CNT_W  display value
vote_ack  output  1  high while a vote acknowledge is shown
armed  output  1  high while a vote may be cast
winner  output  IDX_W  index of leading candidate (result mode only)
tie  output  1  leading tally shared by two or more candidates (result mode only)
sat  output  1  sticky: some tally has saturated

Behaviour:
- Reset (async assert, sync-clean deassert):
  - All tallies and debounce counters = 0.
  - State = IDLE; all outputs = 0.
- Debounce, per channel:
  - Counter clears while btn[i]=0.
  - Counter increments while btn[i]=1, holding at DEBOUNCE_CYC.
  - press[i] is a one-cycle pulse on the cycle the counter reaches DEBOUNCE_CYC.
  - A button held indefinitely gives exactly one pulse; a new pulse requires a release.
- Simultaneous presses: the lowest index wins; other pulses that cycle are dropped.
- FSM states: IDLE, ARMED, ACK, RESULT.
- IDLE:
  - result=0, armed=0.
  - arm=1 -> ARMED.
  - Presses are ignored (not counted).
- ARMED:
  - armed=1.
  - First accepted press[i]:
    - tally[i] += 1, saturating at 2^CNT_W-1.
    - If the increment was blocked by saturation, set sat (sticky until rst).
    - Load ack timer; -> ACK.
  - arm is ignored while ARMED.
- ACK:
  - vote_ack=1, result=all ones.
  - Timer counts ACK_CYC cycles, then -> IDLE with result=0.
  - Presses and arm are ignored; no double-vote.
- mode=1 from IDLE/ARMED/ACK -> RESULT next cycle.
  - A pending arm is discarded.
  - ACK is aborted; the vote already counted stays counted.
- RESULT:
  - press[i] registers result=tally[i] one cycle after the pulse; the value holds until the next press.
  - Tallies are never modified.
  - winner = index of max tally, lowest index on equal max.
  - tie=1 iff max>0 and at least two tallies equal max.
  - winner/tie are registered (1-cycle latency from tally change); both are forced 0 outside RESULT.
  - mode=0 -> IDLE, result=0.
- Tally width rule: all comparisons are unsigned on CNT_W bits; no wrap-around.
- Reset mid-operation: immediate return to reset values, including tallies and the sat flag.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (IDLE, ARMED, ACK, RESULT);
  - default constants for DEBOUNCE_CYC and ACK_CYC;
  - a function for max-index/tie over an array of tallies.
- Sub-module vm_debounce (one instance per channel, generate loop) has ports clk, rst, btn, press, plus parameter DEBOUNCE_CYC.
- FSM, tallies and winner logic are kept in the top.

Test Plan:
All tests use NUM_CAND=4, CNT_W=3, DEBOUNCE_CYC=4, ACK_CYC=3.
1. Single vote: arm pulse; btn[2] high 6 cycles.
   -> armed=1 after arm; tally2=1.
   -> vote_ack=1 and result=3'b111 for 3 cycles, then IDLE with result=0.
2. Unarmed/double vote: btn[1] pressed in IDLE -> no count. Arm; press btn[1] twice within ACK -> tally1=1 only.
3. Simultaneous press and bounce:
   - btn[3] and btn[0] rise same cycle while armed -> only tally0 increments.
   - btn toggling with high runs <4 cycles -> no pulse.
4. Saturation: 8 armed votes for candidate 1 -> tally1 stays 7, sat=1. rst -> sat=0, tallies 0.
5. Result mode: tallies {2,5,5,1}; mode=1; press btn[3].
   -> result=1; winner=1, tie=1.
   -> After one more vote to cand 2: winner=2, tie=0.
   -> mode=0 clears result, winner and tie.
6. Async reset mid-ACK: assert rst between clock edges during ACK -> vote_ack=0 and tallies 0 immediately, state IDLE after release.
